// File: rtl/membus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: default geometry, the
// requester index type and the request/response field bundles of the bus.
package membus_arbiter_pkg;

    localparam int MB_NPORT   = 3;
    localparam int MB_ADDR_W  = 32;
    localparam int MB_DATA_W  = 32;
    localparam int MB_MAX_OUT = 4;

    // Index of a requester port for the default port count
    typedef logic [$clog2(MB_NPORT)-1:0] port_idx_t;

    // Request fields as carried on the memory bus
    typedef struct packed {
        logic [MB_ADDR_W-1:0] addr;
        logic                 wen;
        logic [MB_DATA_W-1:0] wdata;
    } mem_bus_req_t;

    // Response fields as returned by the memory model
    typedef struct packed {
        logic [MB_ADDR_W-1:0] addr;
        logic                 error;
        logic [MB_DATA_W-1:0] rdata;
    } mem_bus_resp_t;

endpackage

// File: rtl/membus_arbiter_tag_fifo.sv
// Small tag FIFO remembering which port issued each outstanding request.
// The head entry is read combinationally so a response can be routed in the
// same cycle it arrives; the storage is tiny and maps to distributed RAM.
module tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Entry storage; contents need no reset because occupancy guards reads
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally since the depth is a power of two
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/membus_arbiter.sv
// Round-robin arbiter sharing one memory bus port among NPORT requesters.
// Requests are granted combinationally, the granted port is queued in a tag
// FIFO, and in-order responses are steered back to the queued port.
module membus_arbiter
    import membus_arbiter_pkg::*;
#(
    parameter int NPORT   = MB_NPORT,
    parameter int ADDR_W  = MB_ADDR_W,
    parameter int DATA_W  = MB_DATA_W,
    parameter int MAX_OUT = MB_MAX_OUT,
    localparam int IDX_W  = $clog2(NPORT),
    localparam int CNT_W  = $clog2(MAX_OUT) + 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NPORT-1:0]        req_valid,
    output logic [NPORT-1:0]        req_ready,
    input  logic [NPORT*ADDR_W-1:0] req_addr,
    input  logic [NPORT-1:0]        req_wen,
    input  logic [NPORT*DATA_W-1:0] req_wdata,
    output logic [NPORT-1:0]        resp_valid,
    output logic [ADDR_W-1:0]       resp_addr,
    output logic                    resp_error,
    output logic [DATA_W-1:0]       resp_rdata,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_W-1:0]       mem_req_addr,
    output logic                    mem_req_wen,
    output logic [DATA_W-1:0]       mem_req_wdata,
    input  logic                    mem_resp_valid,
    input  logic [ADDR_W-1:0]       mem_resp_addr,
    input  logic                    mem_resp_error,
    input  logic [DATA_W-1:0]       mem_resp_rdata,
    output logic [CNT_W-1:0]        outstanding,
    output logic                    spurious_resp
);

    logic [IDX_W-1:0]  r_rr_ptr;
    logic              r_spurious;
    logic [IDX_W-1:0]  w_grant;
    logic [IDX_W-1:0]  w_head;
    logic              w_any_valid;
    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic              w_pop;
    logic [ADDR_W-1:0] w_addr_arr  [NPORT];
    logic [DATA_W-1:0] w_wdata_arr [NPORT];

    // First valid port at or after ptr, scanning upward with wrap-around
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NPORT-1:0] valid,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NPORT; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NPORT) begin
                idx = idx - NPORT;
            end
            if (!found && valid[idx]) begin
                pick  = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Unpack the flat per-port buses so the granted fields can be indexed
    for (genvar gi = 0; gi < NPORT; gi++) begin : g_unpack
        assign w_addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
        assign w_wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end

    assign w_any_valid = |req_valid;
    assign w_grant     = rr_pick(req_valid, r_rr_ptr);

    // Gating with reset_n keeps the request side quiet while reset is held;
    // the full check ignores any same-cycle pop so ready never waits on a response
    assign mem_req_valid = reset_n && w_any_valid && !w_full;
    assign mem_req_addr  = w_addr_arr[w_grant];
    assign mem_req_wen   = req_wen[w_grant];
    assign mem_req_wdata = w_wdata_arr[w_grant];
    assign w_accept      = mem_req_valid && mem_req_ready;
    assign w_pop         = mem_resp_valid && !w_empty;

    // Per-port ready and response strobes
    for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
        assign req_ready[gi]  = w_accept && (w_grant == IDX_W'(gi));
        assign resp_valid[gi] = w_pop && (w_head == IDX_W'(gi));
    end

    assign resp_addr     = mem_resp_addr;
    assign resp_error    = mem_resp_error;
    assign resp_rdata    = mem_resp_rdata;
    assign spurious_resp = r_spurious;

    tag_fifo #(
        .DEPTH (MAX_OUT),
        .WIDTH (IDX_W)
    ) u_tag_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_accept),
        .i_wdata (w_grant),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (outstanding)
    );

    // Advance the round-robin pointer past the port that was just accepted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= (w_grant == IDX_W'(NPORT - 1)) ? '0 : w_grant + IDX_W'(1);
        end
    end

    // Sticky record of a response that had no outstanding request to match
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_spurious <= 1'b0;
        end else if (mem_resp_valid && w_empty) begin
            r_spurious <= 1'b1;
        end
    end

endmodule

// File: tb/tb_membus_arbiter.sv
// Directed bench for membus_arbiter with three ports and four outstanding tags.
module tb_membus_arbiter;

    localparam int NPORT = 3;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic              clk;
    logic              reset_n;
    logic [NPORT-1:0]  req_valid;
    logic [NPORT-1:0]  req_ready;
    logic [NPORT*AW-1:0] req_addr;
    logic [NPORT-1:0]  req_wen;
    logic [NPORT*DW-1:0] req_wdata;
    logic [NPORT-1:0]  resp_valid;
    logic [AW-1:0]     resp_addr;
    logic              resp_error;
    logic [DW-1:0]     resp_rdata;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [AW-1:0]     mem_req_addr;
    logic              mem_req_wen;
    logic [DW-1:0]     mem_req_wdata;
    logic              mem_resp_valid;
    logic [AW-1:0]     mem_resp_addr;
    logic              mem_resp_error;
    logic [DW-1:0]     mem_resp_rdata;
    logic [2:0]        outstanding;
    logic              spurious_resp;

    int n_vec = 0;
    int n_err = 0;

    logic [AW-1:0] a_tab [NPORT];

    membus_arbiter #(
        .NPORT(NPORT), .ADDR_W(AW), .DATA_W(DW), .MAX_OUT(4)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wen(req_wen), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_addr(resp_addr), .resp_error(resp_error),
        .resp_rdata(resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_addr(mem_resp_addr),
        .mem_resp_error(mem_resp_error), .mem_resp_rdata(mem_resp_rdata),
        .outstanding(outstanding), .spurious_resp(spurious_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Step one edge, then land 1 time unit after it for driving inputs
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_resp(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        mem_resp_valid = v;
        mem_resp_addr  = a;
        mem_resp_rdata = d;
    endtask

    initial begin
        a_tab[0] = 32'h0000_1000;
        a_tab[1] = 32'h0000_2000;
        a_tab[2] = 32'h0000_3000;

        reset_n        = 1'b0;
        req_valid      = '0;
        req_addr       = '0;
        req_wen        = '0;
        req_wdata      = '0;
        mem_req_ready  = 1'b1;
        mem_resp_error = 1'b0;
        drive_resp(1'b0, '0, '0);

        // Reset state
        tick();
        tick();
        settle();
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_spurious", 64'(spurious_resp), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        reset_n = 1'b1;

        // Single port 1 read of 0x100, response four cycles later
        tick();
        req_valid = 3'b010;
        req_addr[1*AW +: AW] = 32'h0000_0100;
        settle();
        chk("p1_mem_req_valid", 64'(mem_req_valid), 64'd1);
        chk("p1_mem_req_addr", 64'(mem_req_addr), 64'h100);
        chk("p1_mem_req_wen", 64'(mem_req_wen), 64'd0);
        chk("p1_req_ready", 64'(req_ready), 64'b010);
        tick();
        req_valid = 3'b000;
        settle();
        chk("p1_outstanding_1", 64'(outstanding), 64'd1);
        tick();
        tick();
        tick();
        drive_resp(1'b1, 32'h100, 32'hDEAD_BEEF);
        settle();
        chk("p1_resp_valid", 64'(resp_valid), 64'b010);
        chk("p1_resp_rdata", 64'(resp_rdata), 64'hDEAD_BEEF);
        tick();
        drive_resp(1'b0, '0, '0);
        settle();
        chk("p1_resp_valid_gone", 64'(resp_valid), 64'd0);
        chk("p1_outstanding_0", 64'(outstanding), 64'd0);

        // Fairness from a fresh pointer: all ports valid, one pop per cycle
        reset_n = 1'b0;
        settle();
        reset_n = 1'b1;
        for (int p = 0; p < NPORT; p++) begin
            req_addr[p*AW +: AW]  = a_tab[p];
            req_wdata[p*DW +: DW] = 32'hCAFE_0000 + 32'(p);
        end
        req_wen = 3'b100;
        tick();
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            if (k >= 1) drive_resp(1'b1, a_tab[(k-1)%3], 32'(k));
            else        drive_resp(1'b0, '0, '0);
            settle();
            chk($sformatf("rr_grant_%0d", k), 64'(req_ready), 64'(3'b001 << (k % 3)));
            chk($sformatf("rr_addr_%0d", k), 64'(mem_req_addr), 64'(a_tab[k % 3]));
            chk($sformatf("rr_resp_%0d", k), 64'(resp_valid),
                (k >= 1) ? 64'(3'b001 << ((k - 1) % 3)) : 64'd0);
            chk($sformatf("rr_occ_%0d", k), 64'(outstanding), (k >= 1) ? 64'd1 : 64'd0);
            if (k == 2) begin
                chk("rr_wen_p2", 64'(mem_req_wen), 64'd1);
                chk("rr_wdata_p2", 64'(mem_req_wdata), 64'hCAFE_0002);
            end
            tick();
        end
        req_valid = 3'b000;
        drive_resp(1'b1, a_tab[2], 32'h77);
        settle();
        chk("rr_last_resp", 64'(resp_valid), 64'b100);
        chk("rr_last_addr", 64'(resp_addr), 64'(a_tab[2]));
        tick();
        drive_resp(1'b0, '0, '0);
        settle();
        chk("rr_drained", 64'(outstanding), 64'd0);

        // Downstream stall with ports 0 and 2 waiting
        mem_req_ready = 1'b0;
        req_valid     = 3'b101;
        for (int c = 0; c < 10; c++) begin
            settle();
            chk($sformatf("stall_addr_%0d", c), 64'(mem_req_addr), 64'(a_tab[0]));
            chk($sformatf("stall_ready_%0d", c), 64'(req_ready), 64'd0);
            tick();
        end
        chk("stall_occ", 64'(outstanding), 64'd0);
        mem_req_ready = 1'b1;
        settle();
        chk("stall_release_p0", 64'(req_ready), 64'b001);
        tick();
        settle();
        chk("stall_next_p2", 64'(req_ready), 64'b100);
        tick();
        req_valid = 3'b000;
        drive_resp(1'b1, a_tab[0], 32'h1);
        settle();
        chk("stall_occ_2", 64'(outstanding), 64'd2);
        chk("stall_resp_p0", 64'(resp_valid), 64'b001);
        tick();
        drive_resp(1'b1, a_tab[2], 32'h2);
        settle();
        chk("stall_resp_p2", 64'(resp_valid), 64'b100);
        tick();
        drive_resp(1'b0, '0, '0);

        // Fill the tag FIFO from port 1 with no responses
        req_valid = 3'b010;
        for (int c = 0; c < 4; c++) begin
            settle();
            chk($sformatf("fill_occ_%0d", c), 64'(outstanding), 64'(c));
            tick();
        end
        settle();
        chk("full_occ", 64'(outstanding), 64'd4);
        chk("full_ready", 64'(req_ready), 64'd0);
        chk("full_mem_req_valid", 64'(mem_req_valid), 64'd0);
        drive_resp(1'b1, 32'h0, 32'h5);
        settle();
        chk("full_pop_resp", 64'(resp_valid), 64'b010);
        chk("full_pop_ready", 64'(req_ready), 64'd0);
        tick();
        drive_resp(1'b0, '0, '0);
        settle();
        chk("after_pop_occ", 64'(outstanding), 64'd3);
        chk("after_pop_ready", 64'(req_ready), 64'b010);
        req_valid = 3'b000;
        for (int c = 0; c < 3; c++) begin
            tick();
            drive_resp(1'b1, 32'h0, 32'(c));
        end
        tick();
        drive_resp(1'b0, '0, '0);
        settle();
        chk("fill_drained", 64'(outstanding), 64'd0);

        // Response with nothing outstanding
        drive_resp(1'b1, 32'hBAD, 32'hBAD);
        settle();
        chk("spur_no_route", 64'(resp_valid), 64'd0);
        tick();
        drive_resp(1'b0, '0, '0);
        settle();
        chk("spur_set", 64'(spurious_resp), 64'd1);
        tick();
        tick();
        settle();
        chk("spur_sticky", 64'(spurious_resp), 64'd1);
        reset_n = 1'b0;
        settle();
        chk("spur_async_clear", 64'(spurious_resp), 64'd0);
        reset_n = 1'b1;

        // Reset with two requests in flight
        tick();
        req_valid = 3'b011;
        tick();
        tick();
        req_valid = 3'b100;
        settle();
        chk("mid_occ_2", 64'(outstanding), 64'd2);
        chk("mid_ready_p2", 64'(req_ready), 64'b100);
        reset_n = 1'b0;
        settle();
        chk("mid_rst_occ", 64'(outstanding), 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        chk("mid_rst_mem_valid", 64'(mem_req_valid), 64'd0);
        chk("mid_rst_spur", 64'(spurious_resp), 64'd0);
        req_valid = 3'b000;
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            drive_resp(1'b1, a_tab[c], 32'(c));
            settle();
            chk($sformatf("late_resp_%0d", c), 64'(resp_valid), 64'd0);
            tick();
        end
        drive_resp(1'b0, '0, '0);
        settle();
        chk("late_spur", 64'(spurious_resp), 64'd1);
        chk("late_occ", 64'(outstanding), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/membus_arbiter.md
# membus_arbiter

Round-robin arbiter that shares the single memory bus port between up to NPORT requesters, such as the instruction cache, the data cache and a future DMA/debug master. It sits between the requesters and the memory model. The block forwards one granted request per accepted handshake and records the granted port in a tag FIFO. It routes each in-order memory response back to the port that issued the request. It is intended to replace the fixed two-port bus control with a scalable, fair scheme.

## Interface
Parameters:
- NPORT, 3, number of requesters (2..8)
- ADDR_W, 32, address width (XLEN)
- DATA_W, 32, data width
- MAX_OUT, 4, maximum outstanding requests (tag FIFO depth, power of two)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset_n  in  1  reset, asynchronous and active-low
- req_valid  in  NPORT  per-port request valid
- req_ready  out  NPORT  per-port request accepted this cycle
- req_addr  in  NPORT×ADDR_W  per-port address
- req_wen  in  NPORT  per-port write enable
- req_wdata  in  NPORT×DATA_W  per-port write data
- resp_valid  out  NPORT  per-port response strobe (one cycle)
- resp_addr  out  ADDR_W  response address, shared across ports
- resp_error  out  1  response error, shared across ports
- resp_rdata  out  DATA_W  response data, shared across ports
- mem_req_valid / mem_req_ready  out / in  1  downstream request handshake
- mem_req_addr / mem_req_wen / mem_req_wdata  out  ADDR_W / 1 / DATA_W  forwarded request
- mem_resp_valid / mem_resp_addr / mem_resp_error / mem_resp_rdata  in  1 / ADDR_W / 1 / DATA_W  memory response
- outstanding  out  log2(MAX_OUT)+1  current FIFO occupancy
- spurious_resp  out  1  sticky flag: a response arrived with the FIFO empty

## Operation
- Grant is combinational. Starting at rr_ptr, the arbiter scans ports in ascending index order with wrap-around and takes the first port with req_valid=1.
- mem_req_valid = any req_valid && !fifo_full. The mem_req_* fields carry the granted port's fields.
- req_ready[g] = mem_req_ready && !fifo_full. All other req_ready bits are 0.
- Accept means mem_req_valid && mem_req_ready. On accept:
  - push g into the tag FIFO;
  - set rr_ptr to (g+1) mod NPORT.
- No accept means rr_ptr is held. Requesters must keep their request fields stable until accepted.
- Every accepted request, read or write, produces exactly one memory response, and responses return in order.
- On mem_resp_valid with the FIFO non-empty:
  - pop the head tag h;
  - drive resp_valid[h]=1 for that cycle;
  - pass the shared resp_* fields through unchanged.
- On mem_resp_valid with the FIFO empty: drive no resp_valid, and set spurious_resp to 1. The flag stays set until reset.
- Push and pop may occur in the same cycle; occupancy is then unchanged.
- When the FIFO is full, requests are blocked even if a pop happens in the same cycle. This keeps the ready path free of any dependency on the response.

## Timing
- Request path: zero cycles from req to mem_req. Grant and ready are combinational.
- Response path: zero cycles from mem_resp to resp. Routing is combinational from the FIFO head.
- Reset state (reset_n=0, asynchronous):
  - rr_ptr=0;
  - FIFO empty, outstanding=0;
  - spurious_resp=0;
  - every req_ready=0 and resp_valid=0;
  - mem_req_valid=0.
- Reset during outstanding transactions drops all tags. Memory responses that arrive after reset are spurious and set the flag.
- Fairness: with all ports continuously valid and no stalls, grants rotate 0,1,…,NPORT-1,0. A waiting port is granted within NPORT accepts.
- FIFO pointers wrap modulo MAX_OUT. Occupancy ranges 0..MAX_OUT.

## Structure
- The shared package holds the port-index type (width $clog2(NPORT)) and the MemBusReq/MemBusResp field widths reused from the existing bus definitions.
- One sub-module, tag_fifo: a synchronous FIFO with push/pop/full/empty/count, asynchronous active-low reset, and parameterised depth and width.
- The round-robin search is a function inside membus_arbiter.

## Test plan
- Single port 1 issues a read to 0x100; memory returns rdata 0xDEADBEEF after 4 cycles. Expect resp_valid=3'b010 for exactly one cycle with rdata 0xDEADBEEF, and outstanding goes 1→0.
- All 3 ports hold valid continuously with mem_req_ready=1. Expect accept order 0,1,2,0,1,2. Responses with addrs A0,A1,A2 return to ports 0,1,2 in order.
- mem_req_ready tied to 0 for 10 cycles with ports 0 and 2 valid. Expect no accept, rr_ptr held and mem_req fields stable. After release, port 0 is granted first.
- No responses returned, so MAX_OUT=4 requests fill the FIFO. Expect outstanding=4 and all req_ready=0 even while a response pops. Ready returns the cycle after the pop.
- mem_resp_valid pulsed with the FIFO empty. Expect no resp_valid and spurious_resp=1 sticky. A later reset_n low clears it immediately without waiting for a clock edge.
- Assert reset_n=0 mid-flight with 2 outstanding. Expect outputs at reset values asynchronously. Both late responses are flagged spurious and not routed.
